// File: rtl/draw_arbiter.sv
// -----------------------------------------------------------------------------
// draw_arbiter
//
// Per-frame draw scheduler sharing the single VGA write port between the
// screen drawers. On an accepted frame_start it latches the set of requesting
// drawers and then enables them one at a time, lowest index first. A drawer
// keeps the port until it raises its done flag or until a watchdog forces it
// off after TIMEOUT grant cycles.
//
// Parameters
//   NUM_CLIENTS   number of drawers (index 0 = map, drawn first)
//   TIMEOUT       maximum grant cycles per drawer before a forced release
//
// Ports
//   clock, resetn        system clock, asynchronous active-low reset
//   frame_start          one-cycle pulse starting a frame's draw sequence
//   client_req           drawers wanting a slot (sampled on accepted frame_start)
//   client_done          per-drawer draw_done
//   client_x/y/colour    packed per-drawer pixel coordinates / colour
//   client_write         per-drawer write enable
//   client_en            one-hot (or zero) enable to the drawers
//   vga_x/y/colour/write registered VGA memory write port
//   busy                 high whenever a sequence is in progress
//   frame_done           one-cycle pulse when the sequence completes
//   timeout_err          sticky: a drawer was force-released
//   overrun              sticky: frame_start arrived while busy
//   err_clear            synchronous clear of both sticky flags
// -----------------------------------------------------------------------------
module draw_arbiter #(
    parameter int          NUM_CLIENTS = 4,
    parameter logic [15:0] TIMEOUT     = 16'd50000
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     frame_start,
    input  logic [NUM_CLIENTS-1:0]   client_req,
    input  logic [NUM_CLIENTS-1:0]   client_done,
    input  logic [9*NUM_CLIENTS-1:0] client_x,
    input  logic [8*NUM_CLIENTS-1:0] client_y,
    input  logic [6*NUM_CLIENTS-1:0] client_colour,
    input  logic [NUM_CLIENTS-1:0]   client_write,
    output logic [NUM_CLIENTS-1:0]   client_en,
    output logic [8:0]               vga_x,
    output logic [7:0]               vga_y,
    output logic [5:0]               vga_colour,
    output logic                     vga_write,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     timeout_err,
    output logic                     overrun,
    input  logic                     err_clear
);

    localparam int CUR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SCAN    = 3'd1,
        GRANT   = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_CLIENTS-1:0] pending_q, pending_d;
    logic [CUR_W-1:0]       cur_q, cur_d;
    logic [15:0]            wdog_q, wdog_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   overrun_q, overrun_d;
    logic [8:0]             vga_x_q, vga_x_d;
    logic [7:0]             vga_y_q, vga_y_d;
    logic [5:0]             vga_colour_q, vga_colour_d;
    logic                   vga_write_q, vga_write_d;

    logic [CUR_W-1:0]       low_idx;
    logic                   sel_done;
    logic                   sel_write;
    logic [8:0]             sel_x;
    logic [7:0]             sel_y;
    logic [5:0]             sel_colour;
    logic                   to_event;

    // Lowest set pending bit: walking from the top down lets the lowest index
    // overwrite any higher one.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = CUR_W'(i);
            end
        end
    end

    // Select the current drawer's signals. Done flags of other drawers never
    // reach the FSM through this mux.
    always_comb begin
        sel_done   = 1'b0;
        sel_write  = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (cur_q == CUR_W'(i)) begin
                sel_done   = client_done[i];
                sel_write  = client_write[i];
                sel_x      = client_x[9*i +: 9];
                sel_y      = client_y[8*i +: 8];
                sel_colour = client_colour[6*i +: 6];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cur_d     = cur_q;
        wdog_d    = wdog_q;
        to_event  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    pending_d = client_req;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (pending_q == '0) begin
                    state_d = DONE;
                end else begin
                    cur_d     = low_idx;
                    pending_d = pending_q & ~(NUM_CLIENTS'(1) << low_idx);
                    wdog_d    = '0;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                wdog_d = wdog_q + 16'd1;
                // done has priority over the watchdog in the same cycle
                if (sel_done) begin
                    state_d = RELEASE;
                end else if (wdog_q == TIMEOUT - 16'd1) begin
                    to_event = 1'b1;
                    state_d  = RELEASE;
                end
            end
            RELEASE: state_d = SCAN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sticky flags: a new event in the same cycle as err_clear wins.
    always_comb begin
        timeout_err_d = (timeout_err_q & ~err_clear) | to_event;
        overrun_d     = (overrun_q & ~err_clear) | (frame_start & (state_q != IDLE));
    end

    // Output path: pass the granted drawer through, otherwise hold coordinates
    // and suppress the write.
    always_comb begin
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_write_d  = 1'b0;
        if (state_q == GRANT) begin
            vga_x_d      = sel_x;
            vga_y_d      = sel_y;
            vga_colour_d = sel_colour;
            vga_write_d  = sel_write;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            cur_q         <= '0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            vga_x_q       <= '0;
            vga_y_q       <= '0;
            vga_colour_q  <= '0;
            vga_write_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            cur_q         <= cur_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
            vga_x_q       <= vga_x_d;
            vga_y_q       <= vga_y_d;
            vga_colour_q  <= vga_colour_d;
            vga_write_q   <= vga_write_d;
        end
    end

    // Enables and status decode only registered state, so they cannot glitch.
    always_comb begin
        client_en = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            client_en[i] = (state_q == GRANT) && (cur_q == CUR_W'(i));
        end
    end

    assign busy        = (state_q != IDLE);
    assign frame_done  = (state_q == DONE);
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_colour  = vga_colour_q;
    assign vga_write   = vga_write_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_draw_arbiter
//
// Drives draw_arbiter with directed frames followed by randomized frames.
// Expected behaviour comes from a schedule model: each accepted frame is
// turned into a list of grant windows (start cycle, length) using the
// hand-off arithmetic of the scheduler, and every output is compared each
// cycle against that schedule.
// -----------------------------------------------------------------------------
module tb_draw_arbiter;

    localparam int N  = 4;
    localparam int TO = 100;
    localparam int NEVER = 1000000;

    logic             clock = 1'b0;
    logic             resetn;
    logic             frame_start;
    logic [N-1:0]     client_req;
    logic [N-1:0]     client_done;
    logic [9*N-1:0]   client_x;
    logic [8*N-1:0]   client_y;
    logic [6*N-1:0]   client_colour;
    logic [N-1:0]     client_write;
    logic [N-1:0]     client_en;
    logic [8:0]       vga_x;
    logic [7:0]       vga_y;
    logic [5:0]       vga_colour;
    logic             vga_write;
    logic             busy;
    logic             frame_done;
    logic             timeout_err;
    logic             overrun;
    logic             err_clear;

    draw_arbiter #(
        .NUM_CLIENTS (N),
        .TIMEOUT     (16'd100)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .frame_start   (frame_start),
        .client_req    (client_req),
        .client_done   (client_done),
        .client_x      (client_x),
        .client_y      (client_y),
        .client_colour (client_colour),
        .client_write  (client_write),
        .client_en     (client_en),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_write     (vga_write),
        .busy          (busy),
        .frame_done    (frame_done),
        .timeout_err   (timeout_err),
        .overrun       (overrun),
        .err_clear     (err_clear)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // schedule model of the current frame
    bit   fr_act = 1'b0;
    int   fr_n   = 0;
    int   t_done = 0;
    int   s_cl[$];
    int   s_st[$];
    int   s_len[$];
    bit   s_to[$];
    int   dlen[N];
    int   gcnt[N];
    bit   noise = 1'b0;
    logic e_to, e_ov, e_w;
    logic [8:0] e_x;
    logic [7:0] e_y;
    logic [5:0] e_c;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int grantee(int c);
        if (!fr_act) return -1;
        foreach (s_cl[k]) begin
            if (c >= s_st[k] && c < s_st[k] + s_len[k]) return s_cl[k];
        end
        return -1;
    endfunction

    function automatic bit exp_busy(int c);
        return fr_act && (c >= fr_n + 1) && (c <= t_done);
    endfunction

    function automatic bit to_event(int c);
        if (!fr_act) return 1'b0;
        foreach (s_cl[k]) begin
            if (s_to[k] && c == s_st[k] + TO - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Each granted drawer holds the port for min(done delay, TO) cycles, then
    // two idle cycles (release + scan) precede the next grant or frame_done.
    function automatic void plan(int n, logic [N-1:0] req);
        int t;
        int len;
        fr_act = 1'b1;
        fr_n   = n;
        s_cl.delete(); s_st.delete(); s_len.delete(); s_to.delete();
        t = n + 2;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                len = (dlen[i] <= TO) ? dlen[i] : TO;
                s_cl.push_back(i);
                s_st.push_back(t);
                s_len.push_back(len);
                s_to.push_back(dlen[i] > TO);
                t = t + len + 2;
            end
        end
        t_done = t;
    endfunction

    function automatic void model_reset();
        fr_act = 1'b0;
        s_cl.delete(); s_st.delete(); s_len.delete(); s_to.delete();
        e_to = 1'b0; e_ov = 1'b0; e_w = 1'b0;
        e_x = '0; e_y = '0; e_c = '0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
    endfunction

    // One clock cycle: entered at a falling edge, checks the outputs of the
    // current cycle, drives its inputs, advances to the next falling edge.
    task automatic step(bit fs, logic [N-1:0] req, bit clr);
        int g;
        int ge;
        g  = grantee(cyc);
        ge = (g < 0) ? 0 : (1 << g);
        chk("client_en",   32'(client_en),   32'(ge));
        chk("busy",        32'(busy),        32'(exp_busy(cyc)));
        chk("frame_done",  32'(frame_done),  32'(fr_act && cyc == t_done));
        chk("timeout_err", 32'(timeout_err), 32'(e_to));
        chk("overrun",     32'(overrun),     32'(e_ov));
        chk("vga_write",   32'(vga_write),   32'(e_w));
        chk("vga_x",       32'(vga_x),       32'(e_x));
        chk("vga_y",       32'(vga_y),       32'(e_y));
        chk("vga_colour",  32'(vga_colour),  32'(e_c));

        for (int i = 0; i < N; i++) begin
            if (client_en[i]) begin
                gcnt[i]++;
                client_done[i] = (gcnt[i] == dlen[i]);
            end else begin
                gcnt[i] = 0;
                client_done[i] = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        client_x      = 36'({$urandom(), $urandom()});
        client_y      = $urandom();
        client_colour = 24'($urandom());
        client_write  = 4'($urandom());
        frame_start   = fs;
        client_req    = req;
        err_clear     = clr;

        if (g >= 0) begin
            e_w = client_write[g];
            e_x = client_x[9*g +: 9];
            e_y = client_y[8*g +: 8];
            e_c = client_colour[6*g +: 6];
        end else begin
            e_w = 1'b0;
        end
        e_to = (e_to & ~clr) | to_event(cyc);
        e_ov = (e_ov & ~clr) | (fs && exp_busy(cyc));
        if (fs && !exp_busy(cyc)) plan(cyc, req);

        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic set_d(int d0, int d1, int d2, int d3);
        dlen[0] = d0; dlen[1] = d1; dlen[2] = d2; dlen[3] = d3;
    endtask

    // Run one frame to completion plus one idle cycle. ov_at/clr_at give the
    // offset (from the frame_start cycle) of an extra pulse, or -1.
    task automatic frame(logic [N-1:0] req, int ov_at, int clr_at, bit rnd);
        int  n;
        int  k;
        bit  fs;
        bit  clr;
        n = cyc;
        step(1'b1, req, 1'b0);
        while (cyc <= t_done + 1) begin
            k   = cyc - n;
            fs  = (k == ov_at) || (rnd && exp_busy(cyc) && $urandom_range(0, 19) == 0);
            clr = (k == clr_at) || (rnd && $urandom_range(0, 9) == 0);
            step(fs, 4'($urandom()), clr);
        end
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        frame_start = 1'b0;
        err_clear   = 1'b0;
        client_done = '0;
        #1;
        chk("rst_client_en",   32'(client_en),   32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_frame_done",  32'(frame_done),  32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_overrun",     32'(overrun),     32'd0);
        chk("rst_vga_write",   32'(vga_write),   32'd0);
        chk("rst_vga_xyc",     32'({vga_x, vga_y, vga_colour}), 32'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        cyc++;
    endtask

    initial begin
        resetn        = 1'b0;
        frame_start   = 1'b0;
        client_req    = '0;
        client_done   = '0;
        client_x      = '0;
        client_y      = '0;
        client_colour = '0;
        client_write  = '0;
        err_clear     = 1'b0;
        set_d(1, 1, 1, 1);
        model_reset();
        @(negedge clock);
        do_reset();
        step(1'b0, '0, 1'b0);

        // single long grant just under the watchdog limit
        set_d(90, 1, 1, 1);
        frame(4'b0001, -1, -1, 1'b0);

        // skipped requester, 10-cycle draws
        set_d(10, 10, 10, 10);
        frame(4'b1011, -1, -1, 1'b0);

        // empty frame
        frame(4'b0000, -1, -1, 1'b0);

        // watchdog release, then normal grant; then clear
        set_d(NEVER, 7, 1, 1);
        frame(4'b0011, -1, -1, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // done on the very last allowed cycle beats the watchdog; done at 1
        set_d(TO, 1, TO - 1, 3);
        frame(4'b1111, -1, -1, 1'b0);

        // frame_start while busy
        set_d(8, 8, 8, 8);
        frame(4'b0110, 5, -1, 1'b0);
        step(1'b0, '0, 1'b1);

        // reset in the middle of client 1's grant
        set_d(30, 30, 5, 5);
        step(1'b1, 4'b0011, 1'b0);
        while (grantee(cyc) != 1 && cyc < t_done) step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        do_reset();
        frame(4'b0100, -1, -1, 1'b0);

        // randomized frames with done noise on idle drawers
        noise = 1'b1;
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 9))
                    7:       dlen[i] = TO;
                    8:       dlen[i] = TO - 1;
                    9:       dlen[i] = NEVER;
                    default: dlen[i] = $urandom_range(1, 20);
                endcase
            end
            frame(4'($urandom()), -1, -1, 1'b1);
            for (int j = $urandom_range(0, 3); j > 0; j--) step(1'b0, '0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
